// File: rtl/hd_sweep_pkg.sv
// rtl/hd_sweep_pkg.sv - shared state encoding and width helpers for the Hamming-distance sweeper
package hd_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Bits needed to hold a per-vector Hamming distance in 0..n_out.
    function automatic int hd_width(input int n_out);
        return $clog2(n_out + 1);
    endfunction

    // Total distance can reach 2^n_in * n_out without wrapping.
    function automatic int sum_width(input int n_in, input int n_out);
        return n_in + hd_width(n_out);
    endfunction

    // Error count must hold 2^n_in exactly.
    function automatic int cnt_width(input int n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/popcount_tree.sv
// rtl/popcount_tree.sv - combinational population count of an N-bit vector
module popcount_tree
    import hd_sweep_pkg::*;
#(
    parameter int N = 5,
    parameter int W = hd_width(N)
) (
    input  logic [N-1:0] i_bits,
    output logic [W-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < N; i++) begin
            o_count = o_count + W'(i_bits[i]);
        end
    end

endmodule

// File: rtl/partition_hd_sweeper.sv
// rtl/partition_hd_sweeper.sv - exhaustive input sweeper accumulating Hamming-distance error metrics
module partition_hd_sweeper
    import hd_sweep_pkg::*;
#(
    parameter int N_IN   = 5,
    parameter int N_OUT  = 5,
    parameter int SETTLE = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic [N_IN-1:0]                       pi,
    input  logic [N_OUT-1:0]                      po_exact,
    input  logic [N_OUT-1:0]                      po_approx,
    output logic                                  busy,
    output logic                                  done,
    output logic [sum_width(N_IN, N_OUT)-1:0]     hd_sum,
    output logic [cnt_width(N_IN)-1:0]            err_count,
    output logic [hd_width(N_OUT)-1:0]            max_hd
);

    localparam int HW = hd_width(N_OUT);
    localparam int SW = sum_width(N_IN, N_OUT);
    localparam int CW = cnt_width(N_IN);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N_IN-1:0] r_pi;
    logic [3:0]      r_settle;
    logic [HW-1:0]   r_d;
    logic            r_v;
    logic            r_busy;
    logic            r_done;
    logic [SW-1:0]   r_hd_sum;
    logic [CW-1:0]   r_err;
    logic [HW-1:0]   r_max;
    logic [HW-1:0]   w_hd;
    logic            w_accept;
    logic            w_last;

    popcount_tree #(
        .N (N_OUT),
        .W (HW)
    ) u_popcount (
        .i_bits  (po_exact ^ po_approx),
        .o_count (w_hd)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = start && (r_state == ST_IDLE || r_state == ST_DONE);
        w_last      = &r_pi;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle <= 4'd1) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (w_last) begin
                    w_state_nxt = ST_FLUSH;
                end else begin
                    w_state_nxt = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                end
            end
            ST_FLUSH: w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pi     <= '0;
            r_settle <= '0;
            r_d      <= '0;
            r_v      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hd_sum <= '0;
            r_err    <= '0;
            r_max    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_v     <= 1'b0;
            // Accumulate stage runs one cycle behind the sample it consumes.
            if (r_v) begin
                r_hd_sum <= r_hd_sum + SW'(r_d);
                r_err    <= r_err + CW'(r_d != '0);
                if (r_d > r_max) begin
                    r_max <= r_d;
                end
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_pi     <= '0;
                        r_settle <= SETTLE_LD;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_hd_sum <= '0;
                        r_err    <= '0;
                        r_max    <= '0;
                    end
                end
                ST_SETTLE: r_settle <= r_settle - 4'd1;
                ST_SAMPLE: begin
                    r_d <= w_hd;
                    r_v <= 1'b1;
                    if (!w_last) begin
                        r_pi     <= r_pi + 1'b1;
                        r_settle <= SETTLE_LD;
                    end
                end
                ST_FLUSH: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pi        = r_pi;
    assign busy      = r_busy;
    assign done      = r_done;
    assign hd_sum    = r_hd_sum;
    assign err_count = r_err;
    assign max_hd    = r_max;

endmodule

// File: tb/tb_partition_hd_sweeper.sv
// tb/tb_partition_hd_sweeper.sv - self-checking bench for partition_hd_sweeper
module tb_partition_hd_sweeper;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [4:0] pi0, pi1, pe0, pa0, pe1, pa1;
    logic       busy0, done0, busy1, done1;
    logic [7:0] sum0, sum1;
    logic [5:0] err0, err1;
    logic [2:0] max0, max1;

    logic [4:0] ex_tab [32];
    logic [4:0] m_tab  [32];

    int n_cmp = 0;
    int n_bad = 0;
    int exp_sum, exp_err, exp_max;

    always #5 clk = ~clk;

    assign pe0 = ex_tab[pi0];
    assign pa0 = ex_tab[pi0] ^ m_tab[pi0];
    assign pe1 = ex_tab[pi1];
    assign pa1 = ex_tab[pi1] ^ m_tab[pi1];

    partition_hd_sweeper #(.N_IN(5), .N_OUT(5), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pi(pi0),
        .po_exact(pe0), .po_approx(pa0), .busy(busy0), .done(done0),
        .hd_sum(sum0), .err_count(err0), .max_hd(max0)
    );

    partition_hd_sweeper #(.N_IN(5), .N_OUT(5), .SETTLE(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .pi(pi1),
        .po_exact(pe1), .po_approx(pa1), .busy(busy1), .done(done1),
        .hd_sum(sum1), .err_count(err1), .max_hd(max1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected metrics straight from the per-vector difference masks.
    task automatic model();
        exp_sum = 0;
        exp_err = 0;
        exp_max = 0;
        for (int v = 0; v < 32; v++) begin
            int d;
            d = $countones(m_tab[v]);
            exp_sum += d;
            if (d != 0) exp_err++;
            if (d > exp_max) exp_max = d;
        end
    endtask

    task automatic fill_random();
        for (int v = 0; v < 32; v++) begin
            ex_tab[v] = 5'($urandom);
            m_tab[v]  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
        end
    endtask

    task automatic run_sweep(input int sel, input string tag, input int exp_cyc, input int extra_start_at);
        int k;
        int pi_bad;
        int hold;
        model();
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        chk({tag, ".clear_sum"}, (sel == 0) ? sum0 : sum1, 0);
        chk({tag, ".clear_done"}, (sel == 0) ? done0 : done1, 0);
        k = 0;
        pi_bad = 0;
        while (((sel == 0) ? busy0 : busy1) && k < 400) begin
            hold = (k / 3 > 31) ? 31 : k / 3;
            if (sel == 1 && pi1 != 5'(hold)) pi_bad++;
            if (k == extra_start_at) begin
                if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
            end
            k++;
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
        end
        chk({tag, ".busy_cycles"}, k, exp_cyc);
        chk({tag, ".done"}, (sel == 0) ? done0 : done1, 1);
        chk({tag, ".hd_sum"}, (sel == 0) ? sum0 : sum1, exp_sum);
        chk({tag, ".err_count"}, (sel == 0) ? err0 : err1, exp_err);
        chk({tag, ".max_hd"}, (sel == 0) ? max0 : max1, exp_max);
        chk({tag, ".pi_final"}, (sel == 0) ? pi0 : pi1, 31);
        if (sel == 1) chk({tag, ".pi_hold"}, pi_bad, 0);
    endtask

    initial begin
        int k;
        for (int v = 0; v < 32; v++) begin
            ex_tab[v] = 5'(v);
            m_tab[v]  = 5'd0;
        end

        repeat (2) @(negedge clk);
        chk("reset.pi", pi0, 0);
        chk("reset.busy", busy0, 0);
        chk("reset.done", done0, 0);
        chk("reset.hd_sum", sum0, 0);
        chk("reset.err_count", err0, 0);
        chk("reset.max_hd", max0, 0);
        chk("reset.busy1", busy1, 0);
        rst = 1'b0;

        run_sweep(0, "ident", 33, -1);
        chk("ident.sum_const", sum0, 0);

        for (int v = 0; v < 32; v++) m_tab[v] = 5'h1f;
        run_sweep(0, "invert", 33, -1);
        chk("invert.sum_const", sum0, 160);
        chk("invert.err_const", err0, 32);
        chk("invert.max_const", max0, 5);

        for (int v = 0; v < 32; v++) m_tab[v] = 5'd0;
        m_tab[22] = 5'b01001;
        run_sweep(0, "single", 33, -1);
        chk("single.sum_const", sum0, 2);
        chk("single.err_const", err0, 1);
        chk("single.max_const", max0, 2);

        for (int v = 0; v < 32; v++) m_tab[v] = (v % 2 == 1) ? 5'h10 : 5'h00;
        run_sweep(1, "settle2", 97, -1);
        chk("settle2.sum_const", sum1, 16);
        chk("settle2.err_const", err1, 16);
        chk("settle2.max_const", max1, 1);

        fill_random();
        run_sweep(0, "busy_start", 33, 10);
        run_sweep(0, "done_start", 33, -1);

        for (int it = 0; it < 4; it++) begin
            fill_random();
            run_sweep(0, $sformatf("rand0_%0d", it), 33, -1);
        end
        for (int it = 0; it < 2; it++) begin
            fill_random();
            run_sweep(1, $sformatf("rand1_%0d", it), 97, -1);
        end

        fill_random();
        for (int v = 0; v < 32; v++) m_tab[v] = m_tab[v] | 5'h01;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        k = 0;
        while (pi0 != 5'd12 && k < 100) begin
            k++;
            @(negedge clk);
        end
        chk("midrst.reached_pi12", pi0, 12);
        #2 rst = 1'b1;
        #1;
        chk("midrst.pi", pi0, 0);
        chk("midrst.busy", busy0, 0);
        chk("midrst.done", done0, 0);
        chk("midrst.hd_sum", sum0, 0);
        chk("midrst.err_count", err0, 0);
        chk("midrst.max_hd", max0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst.idle_done", done0, 0);
        run_sweep(0, "after_rst", 33, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
